// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU types: rounding modes and the normalizer stage-1 request
package fpu_pkg;

  localparam int unsigned EXP_BITS  = 8;
  localparam int unsigned MAN_BITS  = 23;
  localparam int unsigned PRE_WIDTH = 28;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } roundmode_e;

  // exp holds the candidate normalized exponent; stage 2 zeroes it for subnormals
  typedef struct packed {
    logic                 sign;
    logic [EXP_BITS-1:0]  exp;
    logic [PRE_WIDTH-1:0] mant;
    logic                 sticky;
    roundmode_e           rnd_mode;
    logic                 eff_sub;
  } norm_req_t;

endpackage

// File: rtl/fpu_utils_lzc.sv
// rtl/fpu_utils_lzc.sv - combinational leading-zero counter with all-zero flag
module fpu_utils_lzc #(
  parameter  int unsigned Width = 28,
  localparam int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic [Width-1:0] in_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             zero_o
);

  // Scan upward so the highest set bit wins; all-zero input reports Width
  always_comb begin
    cnt_o = CntW'(Width);
    for (int i = 0; i < Width; i++) begin
      if (in_i[i]) cnt_o = CntW'(Width - 1 - i);
    end
  end

  assign zero_o = ~|in_i;

endmodule

// File: rtl/fpu_utils_normalize.sv
// rtl/fpu_utils_normalize.sv - two-stage normalizer feeding the FPU rounding stage
module fpu_utils_normalize
  import fpu_pkg::*;
#(
  parameter int unsigned ExpBits  = EXP_BITS,
  parameter int unsigned ManBits  = MAN_BITS,
  parameter int unsigned PreWidth = PRE_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       sign_i,
  input  logic [ExpBits+1:0]         exp_i,
  input  logic [PreWidth-1:0]        mant_i,
  input  logic                       sticky_i,
  input  roundmode_e                 rnd_mode_i,
  input  logic                       eff_sub_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ExpBits+ManBits-1:0] abs_value_o,
  output logic [1:0]                 round_sticky_bits_o,
  output logic                       sign_o,
  output roundmode_e                 rnd_mode_o,
  output logic                       eff_sub_o,
  output logic                       of_before_round_o,
  output logic                       tiny_o
);

  localparam int unsigned ShW = $clog2(PreWidth + 1);
  localparam int unsigned EnW = ExpBits + 3;
  localparam logic signed [EnW-1:0] EnOne = EnW'(1);
  localparam logic signed [EnW-1:0] EnOvf = EnW'((1 << ExpBits) - 1);
  localparam logic signed [EnW-1:0] EnPre = EnW'(PreWidth);

  logic v1_q, v2_q, en1, en2;

  assign en2        = !v2_q || out_ready_i;
  assign en1        = !v1_q || en2;
  assign in_ready_o = en1;

  logic [ShW-1:0]        lz;
  logic                  mant_zero;
  logic signed [EnW-1:0] exp_ext, e_n, rsh;

  fpu_utils_lzc #(.Width(PreWidth)) u_lzc (
    .in_i   (mant_i),
    .cnt_o  (lz),
    .zero_o (mant_zero)
  );

  assign exp_ext = {exp_i[ExpBits+1], exp_i};
  assign e_n     = exp_ext - {{(EnW-ShW){1'b0}}, lz};
  assign rsh     = EnOne - exp_ext;

  norm_req_t      req_d, req_q;
  logic [ShW-1:0] shamt_d, shamt_q;
  logic           shr_d, shr_q, of_d, of_q;

  always_comb begin
    req_d.sign     = sign_i;
    req_d.exp      = ExpBits'(e_n);
    req_d.mant     = mant_i;
    req_d.sticky   = sticky_i;
    req_d.rnd_mode = rnd_mode_i;
    req_d.eff_sub  = eff_sub_i;
    shamt_d        = '0;
    shr_d          = 1'b0;
    of_d           = !mant_zero && (e_n >= EnOvf);
    if (!mant_zero) begin
      if (e_n >= EnOne) begin
        shamt_d = lz;
      end else if (exp_ext >= EnOne) begin
        // Partial normalization: stop where the exponent field reaches 0
        shamt_d = ShW'(exp_ext - EnOne);
      end else begin
        shr_d   = 1'b1;
        shamt_d = (rsh >= EnPre) ? ShW'(PreWidth) : ShW'(rsh);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      req_q   <= '0;
      shamt_q <= '0;
      shr_q   <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      if (flush_i)  v1_q <= 1'b0;
      else if (en1) v1_q <= in_valid_i;
      if (en1 && in_valid_i) begin
        req_q   <= req_d;
        shamt_q <= shamt_d;
        shr_q   <= shr_d;
        of_q    <= of_d;
      end
    end
  end

  logic [2*PreWidth-1:0]       wide;
  logic [PreWidth-1:0]         sh;
  logic                        lost;
  logic [ExpBits-1:0]          exp_field;
  logic [ExpBits+ManBits-1:0]  abs_d, abs_q;
  logic [1:0]                  rs_d, rs_q;
  logic                        tiny_d, tiny_q, ovf_q, sign_q, eff_q;
  roundmode_e                  rnd_q;

  // Lower half of wide collects bits pushed out by a right shift
  always_comb begin
    wide = shr_q ? ({req_q.mant, {PreWidth{1'b0}}} >> shamt_q)
                 : {req_q.mant << shamt_q, {PreWidth{1'b0}}};
    sh        = wide[2*PreWidth-1 -: PreWidth];
    lost      = |wide[PreWidth-1:0];
    exp_field = sh[PreWidth-1] ? req_q.exp : '0;
    if (of_q) begin
      abs_d = {ExpBits'((1 << ExpBits) - 2), {ManBits{1'b1}}};
      rs_d  = 2'b11;
    end else begin
      abs_d = {exp_field, sh[PreWidth-2 -: ManBits]};
      rs_d  = {sh[PreWidth-2-ManBits],
               (|sh[PreWidth-3-ManBits:0]) | req_q.sticky | lost};
    end
    tiny_d = (abs_d[ManBits +: ExpBits] == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v2_q   <= 1'b0;
      abs_q  <= '0;
      rs_q   <= '0;
      tiny_q <= 1'b0;
      ovf_q  <= 1'b0;
      sign_q <= 1'b0;
      rnd_q  <= RNE;
      eff_q  <= 1'b0;
    end else begin
      if (flush_i)  v2_q <= 1'b0;
      else if (en2) v2_q <= v1_q;
      if (en2 && v1_q) begin
        abs_q  <= abs_d;
        rs_q   <= rs_d;
        tiny_q <= tiny_d;
        ovf_q  <= of_q;
        sign_q <= req_q.sign;
        rnd_q  <= req_q.rnd_mode;
        eff_q  <= req_q.eff_sub;
      end
    end
  end

  assign out_valid_o         = v2_q;
  assign abs_value_o         = abs_q;
  assign round_sticky_bits_o = rs_q;
  assign tiny_o              = tiny_q;
  assign of_before_round_o   = ovf_q;
  assign sign_o              = sign_q;
  assign rnd_mode_o          = rnd_q;
  assign eff_sub_o           = eff_q;

endmodule

// File: tb/tb_fpu_utils_normalize.sv
// tb/tb_fpu_utils_normalize.sv - self-checking bench for fpu_utils_normalize
module tb_fpu_utils_normalize;
  import fpu_pkg::*;

  typedef struct {
    logic [30:0] abs;
    logic [1:0]  rs;
    logic        of;
    logic        tiny;
    logic        sign;
    roundmode_e  rm;
    logic        eff;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready_o;
  logic        sign_in = 1'b0;
  logic [9:0]  exp_in = '0;
  logic [27:0] mant_in = '0;
  logic        sticky_in = 1'b0;
  roundmode_e  rm_in = RNE;
  logic        eff_in = 1'b0;
  logic        out_valid_o;
  logic        out_ready = 1'b1;
  logic [30:0] abs_value_o;
  logic [1:0]  rs_o;
  logic        sign_o;
  roundmode_e  rnd_mode_o;
  logic        eff_sub_o;
  logic        of_o;
  logic        tiny_o;

  exp_t sbq[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  logic last_acc = 1'b0;

  always #5 clk = ~clk;

  fpu_utils_normalize dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .flush_i             (flush),
    .in_valid_i          (in_valid),
    .in_ready_o          (in_ready_o),
    .sign_i              (sign_in),
    .exp_i               (exp_in),
    .mant_i              (mant_in),
    .sticky_i            (sticky_in),
    .rnd_mode_i          (rm_in),
    .eff_sub_i           (eff_in),
    .out_valid_o         (out_valid_o),
    .out_ready_i         (out_ready),
    .abs_value_o         (abs_value_o),
    .round_sticky_bits_o (rs_o),
    .sign_o              (sign_o),
    .rnd_mode_o          (rnd_mode_o),
    .eff_sub_o           (eff_sub_o),
    .of_before_round_o   (of_o),
    .tiny_o              (tiny_o)
  );

  // Reference: the result is m*2^(e-27) in units of 2^-bias; express it as a
  // 28-bit significand at the field's scale 2^(max(E,1)-27) plus 64 fraction bits.
  function automatic exp_t model(input logic [27:0] m, input int e, input logic st,
                                 input logic sg, input roundmode_e rm, input logic ef);
    exp_t r;
    logic [127:0] full;
    logic [27:0]  sig;
    logic         lost;
    int p, en, ee, s, d;
    r.sign = sg; r.rm = rm; r.eff = ef; r.of = 1'b0;
    if (m == 0) begin
      r.abs = '0; r.rs = {1'b0, st}; r.tiny = 1'b1;
      return r;
    end
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    en = e - (27 - p);
    if (en >= 255) begin
      r.of = 1'b1; r.abs = {8'd254, 23'h7FFFFF}; r.rs = 2'b11; r.tiny = 1'b0;
      return r;
    end
    ee = (en >= 1) ? en : 0;
    s  = (ee >= 1) ? ee : 1;
    d  = e - s;
    if (d + 64 >= 0) begin
      full = {100'd0, m} << (d + 64);
      lost = 1'b0;
    end else begin
      full = '0;
      lost = 1'b1;
    end
    sig    = full[91:64];
    r.abs  = {ee[7:0], sig[26:4]};
    r.rs   = {sig[3], (|sig[2:0]) | (|full[63:0]) | lost | st};
    r.tiny = (ee == 0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic compare_out(input exp_t e);
    check("abs", {1'b0, abs_value_o}, {1'b0, e.abs});
    check("rs", {30'd0, rs_o}, {30'd0, e.rs});
    check("of", {31'd0, of_o}, {31'd0, e.of});
    check("tiny", {31'd0, tiny_o}, {31'd0, e.tiny});
    check("sign", {31'd0, sign_o}, {31'd0, e.sign});
    check("rnd_mode", {29'd0, rnd_mode_o}, {29'd0, e.rm});
    check("eff_sub", {31'd0, eff_sub_o}, {31'd0, e.eff});
  endtask

  task automatic tick();
    #1;
    if (out_valid_o === 1'b1) begin
      if (sbq.size() == 0) check("spurious_out", {31'd0, out_valid_o}, 32'd0);
      else if (out_ready) compare_out(sbq.pop_front());
      else compare_out(sbq[0]);
    end
    last_acc = in_valid && (in_ready_o === 1'b1) && !flush && !rst;
    if (last_acc) sbq.push_back(cur);
    @(posedge clk);
    #1;
    if (flush || rst) sbq.delete();
  endtask

  task automatic drive(input logic [27:0] m, input int e, input logic st);
    mant_in   = m;
    exp_in    = e[9:0];
    sticky_in = st;
    sign_in   = 1'($urandom_range(0, 1));
    rm_in     = roundmode_e'($urandom_range(0, 4));
    eff_in    = 1'($urandom_range(0, 1));
    in_valid  = 1'b1;
  endtask

  task automatic dir(input logic [27:0] m, input int e, input logic st,
                     input logic [30:0] a, input logic [1:0] rs, input logic of, input logic tiny);
    drive(m, e, st);
    cur.abs = a; cur.rs = rs; cur.of = of; cur.tiny = tiny;
    cur.sign = sign_in; cur.rm = rm_in; cur.eff = eff_in;
  endtask

  task automatic rnd_vec();
    int e;
    logic [27:0] m;
    case ($urandom_range(0, 3))
      0:       e = int'($urandom_range(0, 1023)) - 512;
      1:       e = int'($urandom_range(1, 40));
      2:       e = int'($urandom_range(0, 40)) - 40;
      default: e = int'($urandom_range(240, 290));
    endcase
    if ($urandom_range(0, 9) == 0) m = '0;
    else m = 28'($urandom) >> $urandom_range(0, 27);
    drive(m, e, 1'($urandom_range(0, 1)));
    cur = model(m, e, sticky_in, sign_in, rm_in, eff_in);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sbq.size() > 0; k++) tick();
    check("drain_empty", sbq.size(), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_abs", {1'b0, abs_value_o}, 32'd0);
    check("rst_rs", {30'd0, rs_o}, 32'd0);
    check("rst_tiny", {31'd0, tiny_o}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);

    dir(28'h8000000, 127, 1'b0, {8'd127, 23'h0}, 2'b00, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("lat_cycle1", {31'd0, out_valid_o}, 32'd0);
    tick();
    check("lat_cycle2", {31'd0, out_valid_o}, 32'd1);
    tick();

    dir(28'h8000000, 127, 1'b0, {8'd127, 23'h0},      2'b00, 1'b0, 1'b0); tick();
    dir(28'h0100000, 127, 1'b0, {8'd120, 23'h0},      2'b00, 1'b0, 1'b0); tick();
    dir(28'h8000000, -2,  1'b0, {8'd0, 23'h100000},   2'b00, 1'b0, 1'b1); tick();
    dir(28'h8000003, 127, 1'b0, {8'd127, 23'h0},      2'b01, 1'b0, 1'b0); tick();
    dir(28'h8000008, 127, 1'b0, {8'd127, 23'h0},      2'b10, 1'b0, 1'b0); tick();
    dir(28'h8000000, 255, 1'b0, {8'd254, 23'h7FFFFF}, 2'b11, 1'b1, 1'b0); tick();
    dir(28'h0000000, 100, 1'b1, 31'h0,                2'b01, 1'b0, 1'b1); tick();
    dir(28'h8000000, -30, 1'b0, 31'h0,                2'b01, 1'b0, 1'b1); tick();
    dir(28'h8000000, 1,   1'b0, {8'd1, 23'h0},        2'b00, 1'b0, 1'b0); tick();
    dir(28'h4000000, 1,   1'b0, {8'd0, 23'h400000},   2'b00, 1'b0, 1'b1); tick();
    dir(28'h8000000, 254, 1'b0, {8'd254, 23'h0},      2'b00, 1'b0, 1'b0); tick();
    dir(28'h8000000, 0,   1'b0, {8'd0, 23'h400000},   2'b00, 1'b0, 1'b1); tick();
    dir(28'h0000001, 130, 1'b0, {8'd103, 23'h0},      2'b00, 1'b0, 1'b0); tick();
    drain();

    for (int n = 0; n < 400; n++) begin
      if (!in_valid || last_acc) begin
        if ($urandom_range(0, 3) != 0) rnd_vec();
        else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    out_ready = 1'b0;
    dir(28'h8000000, 127, 1'b0, {8'd127, 23'h0}, 2'b00, 1'b0, 1'b0); tick();
    dir(28'h0100000, 127, 1'b0, {8'd120, 23'h0}, 2'b00, 1'b0, 1'b0); tick();
    dir(28'h8000008, 127, 1'b0, {8'd127, 23'h0}, 2'b10, 1'b0, 1'b0);
    #1;
    check("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid_o}, 32'd1);
    tick();
    tick();
    check("bp_no_accept", {31'd0, last_acc}, 32'd0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_stream2", {31'd0, out_valid_o}, 32'd1);
    tick();
    check("bp_stream3", {31'd0, out_valid_o}, 32'd1);
    tick();
    check("bp_empty", {31'd0, out_valid_o}, 32'd0);

    out_ready = 1'b0;
    dir(28'h8000000, 127, 1'b0, {8'd127, 23'h0}, 2'b00, 1'b0, 1'b0); tick();
    dir(28'h0100000, 127, 1'b0, {8'd120, 23'h0}, 2'b00, 1'b0, 1'b0); tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready_o}, 32'd1);
    out_ready = 1'b1;
    dir(28'h8000003, 127, 1'b0, {8'd127, 23'h0}, 2'b01, 1'b0, 1'b0); tick();
    in_valid = 1'b0;
    check("flush_lat1", {31'd0, out_valid_o}, 32'd0);
    tick();
    check("flush_lat2", {31'd0, out_valid_o}, 32'd1);
    tick();

    dir(28'h8000000, 127, 1'b0, {8'd127, 23'h0}, 2'b00, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    check("flush_prio", {31'd0, out_valid_o}, 32'd0);

    out_ready = 1'b0;
    dir(28'h8000000, 255, 1'b0, {8'd254, 23'h7FFFFF}, 2'b11, 1'b1, 1'b0); tick();
    dir(28'h0000000, 100, 1'b1, 31'h0, 2'b01, 1'b0, 1'b1); tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst2_abs", {1'b0, abs_value_o}, 32'd0);
    check("rst2_rs", {30'd0, rs_o}, 32'd0);
    check("rst2_of", {31'd0, of_o}, 32'd0);
    out_ready = 1'b1;
    dir(28'h0100000, 127, 1'b0, {8'd120, 23'h0}, 2'b00, 1'b0, 1'b0); tick();
    in_valid = 1'b0;
    tick();
    check("rst2_lat2", {31'd0, out_valid_o}, 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
